cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 miss_detected  input  1  cache miss in the current cycle (I-cache or D-cache), level signal.
REQ-005 miss_address  input  16  byte address of the missing access.
REQ-006 memory_data_valid  input  1  main memory returns one word this cycle.
REQ-007 memory_data  input  16  returned word, qualified by memory_data_valid.
REQ-008 fsm_busy  output  1  fill in progress; the pipeline stalls while high.
REQ-009 mem_read_en  output  1  read request to main memory this cycle.
REQ-010 memory_address  output  16  word-aligned request address, qualified by mem_read_en.
REQ-011 write_data_array  output  1  write the fill word into the cache data array this cycle.
REQ-012 fill_word_index  output  3  word slot (0-7) of the current fill word.
REQ-013 fill_data  output  16  copy of memory_data, qualified by write_data_array.
REQ-014 write_tag_array  output  1  write the tag and set the valid bit for the filled block this cycle.

Function
REQ-015 Block geometry SHALL be 16 bytes, i.e. 8 16-bit words; memory SHALL be pipelined with a fixed, unknown-to-the-block latency of at least 1 cycle.
REQ-016 The FSM SHALL have two states, IDLE and FILL; the reset state is IDLE.
REQ-017 IDLE -> FILL SHALL occur on the edge where miss_detected=1; on that edge the block SHALL latch base = {miss_address[15:4], 4'b0000}.
REQ-018 fsm_busy SHALL equal (state==FILL); it rises one cycle after miss_detected is sampled.
REQ-019 A 4-bit request counter req_cnt SHALL clear on entry to FILL.
REQ-020 In FILL, mem_read_en SHALL be 1 when req_cnt<8, with memory_address = base + {req_cnt[2:0],1'b0}; req_cnt increments each such cycle.
REQ-021 mem_read_en SHALL be high for exactly 8 consecutive cycles starting with the first FILL cycle, with addresses base+0, +2, ... +14 in order, each issued once.
REQ-022 A 4-bit receive counter rcv_cnt SHALL clear on entry to FILL.
REQ-023 In FILL, each memory_data_valid=1 cycle SHALL assert write_data_array combinationally, with fill_word_index=rcv_cnt[2:0] and fill_data=memory_data; rcv_cnt increments on that edge.
REQ-024 When memory_data_valid=1 and rcv_cnt==7, write_tag_array SHALL assert in the same cycle, and the FSM SHALL return to IDLE on that edge.
REQ-025 miss_detected while in FILL SHALL be ignored; base SHALL NOT change until the next IDLE acceptance.
REQ-026 memory_data_valid in IDLE SHALL be ignored: no array writes and no counter change.
REQ-027 A miss_detected=1 sampled in the cycle fsm_busy falls SHALL start a new fill the next cycle (back-to-back fills, one IDLE cycle minimum).
REQ-028 Counters SHALL NOT wrap; req_cnt saturates at 8, and rcv_cnt never exceeds 7 within a fill.
REQ-029 Gaps in memory_data_valid SHALL only stall rcv_cnt; a fill completes only after 8 valid words.
REQ-030 In IDLE, all outputs other than memory_address SHALL be 0, and memory_address SHALL be 16'h0000.

Reset
REQ-031 When rst_n=0 at a clock edge, state SHALL become IDLE, req_cnt=rcv_cnt=0 and base=16'h0000, so that every output reads 0 the following cycle.
REQ-032 Reset asserted mid-FILL SHALL abort the fill with no further write_data_array or write_tag_array pulses; words returning after reset SHALL be ignored per REQ-026.

Verification
REQ-033 miss_address=16'h1236 for 1 cycle, memory latency 4 -> mem_read_en for 8 cycles at 1230,1232,...,123E; write_data_array at indices 0..7; write_tag_array on the 8th word; fsm_busy high for 12 cycles.
REQ-034 miss_detected held high throughout a fill with miss_address changing to 16'h4000 -> all 8 requests stay at base 16'h1230; a second fill at 16'h4000 starts after one IDLE cycle.
REQ-035 memory_data_valid withheld for 3 cycles between words 3 and 4 -> indices stay in order; write_tag_array occurs only with word 7; fsm_busy stays high across the gap.
REQ-036 rst_n=0 after 5 words -> outputs are 0 the next cycle; 3 trailing valids produce no writes; a new miss at 16'hFFF0 fills addresses FFF0..FFFE with no wrap past FFFE.
REQ-037 memory_data_valid pulsed while IDLE with data 16'hBEEF -> write_data_array=0 and fsm_busy=0.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss it issues eight pipelined word reads
// for the aligned 16-byte block, writes each returned word into the data
// array in arrival order, and writes the tag with the eighth word.
module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data,
  output logic        fsm_busy,
  output logic        mem_read_en,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  fill_word_index,
  output logic [15:0] fill_data,
  output logic        write_tag_array
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [3:0]  req_cnt_q, req_cnt_d;
  logic [3:0]  rcv_cnt_q, rcv_cnt_d;

  // Next-state and output decode; every output defaults to 0 so IDLE is quiet.
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    req_cnt_d        = req_cnt_q;
    rcv_cnt_d        = rcv_cnt_q;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = 16'h0000;
    write_data_array = 1'b0;
    fill_word_index  = 3'd0;
    fill_data        = 16'h0000;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        // Returned words while idle are stale and deliberately dropped.
        if (miss_detected) begin
          state_d   = FILL;
          base_d    = {miss_address[15:4], 4'b0000};
          req_cnt_d = 4'd0;
          rcv_cnt_d = 4'd0;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        // Request side: eight back-to-back reads, then hold at 8.
        if (req_cnt_q < 4'd8) begin
          mem_read_en    = 1'b1;
          memory_address = base_q + {12'h000, req_cnt_q[2:0], 1'b0};
          req_cnt_d      = req_cnt_q + 4'd1;
        end
        // Receive side: words arrive in request order; gaps just stall.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_word_index  = rcv_cnt_q[2:0];
          fill_data        = memory_data;
          if (rcv_cnt_q == 4'd7) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
            req_cnt_d       = 4'd0;
            rcv_cnt_d       = 4'd0;
          end else begin
            rcv_cnt_d = rcv_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, base address and counters, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= 16'h0000;
      req_cnt_q <= 4'd0;
      rcv_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      req_cnt_q <= req_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a latency-configurable memory
// responder feeds the DUT, and a transaction-level model of the fill rules
// supplies the expected outputs for every cycle.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n, miss_detected, memory_data_valid;
  logic [15:0] miss_address, memory_data;
  logic        fsm_busy, mem_read_en, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_data;
  logic [2:0]  fill_word_index;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .memory_data_valid(memory_data_valid),
    .memory_data      (memory_data),
    .fsm_busy         (fsm_busy),
    .mem_read_en      (mem_read_en),
    .memory_address   (memory_address),
    .write_data_array (write_data_array),
    .fill_word_index  (fill_word_index),
    .fill_data        (fill_data),
    .write_tag_array  (write_tag_array)
  );

  typedef struct packed {
    logic        busy;
    logic        rd;
    logic [15:0] addr;
    logic        wda;
    logic [2:0]  idx;
    logic [15:0] fd;
    logic        wta;
  } outs_t;

  typedef struct packed {
    logic [31:0] due;
    logic [15:0] data;
  } rsp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  outs_t obs_q[$];
  outs_t exp_q[$];
  logic [15:0] rd_log[$];
  int idx_log[$];
  int wta_log[$];
  int busy_cycles;
  int valid_cnt;

  // Memory responder state
  rsp_t mem_q[$];
  int   lat = 1;
  bit   hold = 0;
  bit   rand_gaps = 0;
  bit   force_v = 0;
  logic [15:0] force_d = 16'h0;

  // Fill model: busy flag, aligned base, requests issued, words received
  bit          m_busy = 0;
  logic [15:0] m_base = 16'h0;
  int          m_issued = 0;
  int          m_got = 0;
  int          m_fills = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  task automatic clear_logs();
    obs_q.delete(); exp_q.delete(); rd_log.delete();
    idx_log.delete(); wta_log.delete();
    busy_cycles = 0; valid_cnt = 0;
  endtask

  // One clock: drive memory response, sample outputs mid-cycle, advance model.
  task automatic step();
    outs_t o, e;
    bit v;
    logic [15:0] d;
    v = 1'b0;
    d = 16'($urandom);
    if (force_v) begin
      v = 1'b1; d = force_d;
    end else if (mem_q.size() > 0 && mem_q[0].due <= 32'(cyc) && !hold &&
                 !(rand_gaps && $urandom_range(0, 2) == 0)) begin
      v = 1'b1; d = mem_q[0].data;
    end
    memory_data_valid = v;
    memory_data = d;
    @(negedge clk);
    o = '{fsm_busy, mem_read_en, memory_address, write_data_array,
          fill_word_index, fill_data, write_tag_array};
    e.busy = m_busy;
    e.rd   = m_busy && (m_issued < 8);
    e.addr = e.rd ? m_base + 16'(2 * m_issued) : 16'h0000;
    e.wda  = m_busy && v;
    e.idx  = e.wda ? 3'(m_got) : 3'd0;
    e.fd   = e.wda ? d : 16'h0000;
    e.wta  = e.wda && (m_got == 7);
    obs_q.push_back(o);
    exp_q.push_back(e);
    if (o.rd)   rd_log.push_back(o.addr);
    if (o.wda)  idx_log.push_back(int'(o.idx));
    if (o.wta)  wta_log.push_back(int'(o.idx));
    if (o.busy) busy_cycles++;
    if (v) valid_cnt++;
    if (v && !force_v) mem_q.delete(0);
    if (o.rd) mem_q.push_back('{32'(cyc + lat), mem_word(o.addr)});
    if (!rst_n) begin
      m_busy = 0; m_issued = 0; m_got = 0;
    end else if (m_busy) begin
      if (m_issued < 8) m_issued++;
      if (v) begin
        m_got++;
        if (m_got == 8) m_busy = 0;
      end
    end else if (miss_detected) begin
      m_busy = 1; m_base = {miss_address[15:4], 4'h0};
      m_issued = 0; m_got = 0; m_fills++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    clear_logs();
    rst_n = 1'b0; miss_detected = 1'b1; miss_address = 16'h1236;
    force_v = 1'b1; force_d = 16'hA5A5;
    repeat (3) step();
    force_v = 1'b0; rst_n = 1'b1; miss_detected = 1'b0;
    step();
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_cycle%0d outputs got=%h expected=%h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q[3] !== '0) begin
      failures++;
      $display("FAIL reset_all_zero got=%h expected=0", obs_q[3]);
    end
  endtask

  task automatic test_basic();
    int n;
    clear_logs();
    lat = 4;
    miss_detected = 1'b1; miss_address = 16'h1236;
    step();
    miss_detected = 1'b0; miss_address = 16'($urandom);
    n = 0;
    while ((m_busy || mem_q.size() > 0) && n < 60) begin step(); n++; end
    step();
    checks++;
    if (n >= 60) begin failures++; $display("FAIL basic_timeout got=%0d cycles expected<60", n); end
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL basic_cycle%0d outputs got=%h expected=%h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (busy_cycles != 12) begin failures++; $display("FAIL basic_busy_len got=%0d expected=12", busy_cycles); end
    checks++;
    if (rd_log.size() != 8) begin failures++; $display("FAIL basic_req_count got=%0d expected=8", rd_log.size()); end
    foreach (rd_log[k]) begin
      checks++;
      if (rd_log[k] !== 16'h1230 + 16'(2 * k)) begin
        failures++; $display("FAIL basic_req%0d got=%h expected=%h", k, rd_log[k], 16'h1230 + 16'(2 * k));
      end
    end
    foreach (idx_log[k]) begin
      checks++;
      if (idx_log[k] != k) begin failures++; $display("FAIL basic_idx%0d got=%0d expected=%0d", k, idx_log[k], k); end
    end
    checks++;
    if (wta_log.size() != 1 || wta_log[0] != 7) begin
      failures++; $display("FAIL basic_tag got=%0d pulses expected=1 at index 7", wta_log.size());
    end
  endtask

  task automatic test_miss_held();
    int n, phase, run;
    clear_logs();
    lat = $urandom_range(1, 5);
    m_fills = 0;
    miss_detected = 1'b1; miss_address = 16'h1236;
    step();
    miss_address = 16'h4000;
    n = 0;
    while ((m_fills < 2 || m_busy || mem_q.size() > 0) && n < 150) begin
      if (m_fills >= 2 && m_busy) miss_detected = 1'b0;
      step(); n++;
    end
    miss_detected = 1'b0;
    checks++;
    if (n >= 150) begin failures++; $display("FAIL held_timeout got=%0d cycles expected<150", n); end
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL held_cycle%0d outputs got=%h expected=%h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (rd_log.size() != 16) begin failures++; $display("FAIL held_req_count got=%0d expected=16", rd_log.size()); end
    foreach (rd_log[k]) begin
      checks++;
      if (rd_log[k] !== ((k < 8) ? 16'h1230 : 16'h4000) + 16'(2 * (k % 8))) begin
        failures++; $display("FAIL held_req%0d got=%h", k, rd_log[k]);
      end
    end
    phase = 0; run = 0;
    foreach (obs_q[i]) begin
      if (phase == 0 && obs_q[i].busy) phase = 1;
      else if (phase == 1 && !obs_q[i].busy) begin phase = 2; run = 1; end
      else if (phase == 2) begin
        if (obs_q[i].busy) phase = 3; else run++;
      end
    end
    checks++;
    if (phase != 3 || run != 1) begin
      failures++; $display("FAIL held_idle_gap got=%0d idle cycles expected=1", run);
    end
  endtask

  task automatic test_gap();
    int n, gap_left, first, last;
    clear_logs();
    lat = 2;
    miss_detected = 1'b1; miss_address = 16'($urandom);
    step();
    miss_detected = 1'b0;
    gap_left = 3; n = 0;
    while ((m_busy || mem_q.size() > 0) && n < 60) begin
      hold = (m_got == 4 && gap_left > 0);
      if (hold) gap_left--;
      step(); n++;
    end
    hold = 1'b0;
    checks++;
    if (n >= 60) begin failures++; $display("FAIL gap_timeout got=%0d cycles expected<60", n); end
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL gap_cycle%0d outputs got=%h expected=%h", i, obs_q[i], exp_q[i]);
      end
    end
    foreach (idx_log[k]) begin
      checks++;
      if (idx_log[k] != k) begin failures++; $display("FAIL gap_idx%0d got=%0d expected=%0d", k, idx_log[k], k); end
    end
    checks++;
    if (wta_log.size() != 1 || wta_log[0] != 7) begin
      failures++; $display("FAIL gap_tag got=%0d pulses expected=1 at index 7", wta_log.size());
    end
    first = -1; last = -1;
    foreach (obs_q[i]) if (obs_q[i].busy) begin if (first < 0) first = i; last = i; end
    checks++;
    if (busy_cycles != 13 || (last - first + 1) != 13) begin
      failures++; $display("FAIL gap_busy got=%0d busy over span %0d expected=13 contiguous", busy_cycles, last - first + 1);
    end
  endtask

  task automatic test_reset_mid();
    int n, rst_at, trailing, writes_after;
    clear_logs();
    lat = 3;
    miss_detected = 1'b1; miss_address = 16'($urandom);
    step();
    miss_detected = 1'b0;
    n = 0;
    while (m_got < 5 && n < 40) begin step(); n++; end
    checks++;
    if (n >= 40) begin failures++; $display("FAIL rstmid_timeout got=%0d cycles expected<40", n); end
    rst_at = obs_q.size();
    rst_n = 1'b0; hold = 1'b1;
    step();
    rst_n = 1'b1; hold = 1'b0;
    valid_cnt = 0; n = 0;
    while (mem_q.size() > 0 && n < 20) begin step(); n++; end
    trailing = valid_cnt;
    writes_after = 0;
    for (int i = rst_at + 1; i < obs_q.size(); i++)
      if (obs_q[i].wda || obs_q[i].wta) writes_after++;
    checks++;
    if (obs_q[rst_at + 1] !== '0) begin
      failures++; $display("FAIL rstmid_zero got=%h expected=0", obs_q[rst_at + 1]);
    end
    checks++;
    if (trailing != 3 || writes_after != 0) begin
      failures++; $display("FAIL rstmid_trailing got=%0d writes from %0d valids expected=0 from 3", writes_after, trailing);
    end
    rd_log.delete();
    miss_detected = 1'b1; miss_address = 16'hFFF0;
    step();
    miss_detected = 1'b0;
    n = 0;
    while ((m_busy || mem_q.size() > 0) && n < 60) begin step(); n++; end
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rstmid_cycle%0d outputs got=%h expected=%h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (rd_log.size() != 8) begin failures++; $display("FAIL top_req_count got=%0d expected=8", rd_log.size()); end
    foreach (rd_log[k]) begin
      checks++;
      if (rd_log[k] !== 16'hFFF0 + 16'(2 * k)) begin
        failures++; $display("FAIL top_req%0d got=%h expected=%h", k, rd_log[k], 16'hFFF0 + 16'(2 * k));
      end
    end
  endtask

  task automatic test_idle_valid();
    clear_logs();
    miss_detected = 1'b0;
    force_v = 1'b1; force_d = 16'hBEEF;
    repeat (4) step();
    force_v = 1'b0;
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i].wda !== 1'b0 || obs_q[i].busy !== 1'b0 || obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL idle_valid_cycle%0d outputs got=%h expected=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    clear_logs();
    rand_gaps = 1'b1;
    for (int f = 0; f < 6; f++) begin
      lat = $urandom_range(1, 6);
      n = 0;
      while (n < 40) begin
        miss_detected = ($urandom_range(0, 3) != 0);
        miss_address = 16'($urandom);
        step(); n++;
      end
    end
    miss_detected = 1'b0;
    n = 0;
    while ((m_busy || mem_q.size() > 0) && n < 200) begin step(); n++; end
    rand_gaps = 1'b0;
    checks++;
    if (n >= 200) begin failures++; $display("FAIL random_drain_timeout got=%0d cycles expected<200", n); end
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL random_cycle%0d outputs got=%h expected=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; miss_detected = 1'b0; miss_address = 16'h0;
    memory_data_valid = 1'b0; memory_data = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_miss_held();
    test_gap();
    test_reset_mid();
    test_idle_valid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
